// File: rtl/baccarat_sequencer.sv
// Baccarat round sequencer: deals four to six cards from an external
// source, applies the tableau rules, and flags the winner.
module baccarat_sequencer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       start,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEAL_P1,
    S_DEAL_D1,
    S_DEAL_P2,
    S_DEAL_D2,
    S_DECIDE,
    S_DEAL_P3,
    S_DEAL_D3,
    S_RESULT
  } state_t;

  state_t     r_state;
  logic       r_card_req;
  logic [3:0] r_pcard1;
  logic [3:0] r_pcard2;
  logic [3:0] r_pcard3;
  logic [3:0] r_dcard1;
  logic [3:0] r_dcard2;
  logic [3:0] r_dcard3;
  logic       r_player_win;
  logic       r_dealer_win;
  logic       r_done;

  logic       w_xfer;
  logic [3:0] w_pcard3_n;
  logic [3:0] w_dcard3_n;
  logic [3:0] w_pscore;
  logic [3:0] w_dscore;
  logic [3:0] w_pscore_n;
  logic [3:0] w_dscore_n;
  logic [3:0] w_v;
  logic       w_natural;
  logic       w_bank_draw;

  function automatic logic [3:0] card_val(
    input logic [3:0] c
  );
    if (c >= 4'd1 && c <= 4'd9)
      return c;
    return 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] c
  );
    logic [4:0] s;
    s = {1'b0, card_val(a)}
      + {1'b0, card_val(b)}
      + {1'b0, card_val(c)};
    if (s >= 5'd20)
      s = s - 5'd20;
    else if (s >= 5'd10)
      s = s - 5'd10;
    return s[3:0];
  endfunction

  assign w_xfer = r_card_req & card_valid;

  // Only a third card can land on the edge that enters RESULT,
  // so the look-ahead scores just fold in those two slots.
  assign w_pcard3_n =
    (w_xfer && r_state == S_DEAL_P3) ? card_in : r_pcard3;
  assign w_dcard3_n =
    (w_xfer && r_state == S_DEAL_D3) ? card_in : r_dcard3;

  assign w_pscore = hand_score(r_pcard1, r_pcard2, r_pcard3);
  assign w_dscore = hand_score(r_dcard1, r_dcard2, r_dcard3);
  assign w_pscore_n = hand_score(r_pcard1, r_pcard2, w_pcard3_n);
  assign w_dscore_n = hand_score(r_dcard1, r_dcard2, w_dcard3_n);

  assign w_v = card_val(card_in);
  assign w_natural = (w_pscore >= 4'd8) || (w_dscore >= 4'd8);

  always_comb begin
    w_bank_draw = 1'b0;
    unique case (1'b1)
      (w_dscore <= 4'd2):
        w_bank_draw = 1'b1;
      (w_dscore == 4'd3):
        w_bank_draw = (w_v != 4'd8);
      (w_dscore == 4'd4):
        w_bank_draw = (w_v >= 4'd2) && (w_v <= 4'd7);
      (w_dscore == 4'd5):
        w_bank_draw = (w_v >= 4'd4) && (w_v <= 4'd7);
      (w_dscore == 4'd6):
        w_bank_draw = (w_v >= 4'd6) && (w_v <= 4'd7);
      default:
        w_bank_draw = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state      <= S_IDLE;
      r_card_req   <= 1'b0;
      r_pcard1     <= 4'd0;
      r_pcard2     <= 4'd0;
      r_pcard3     <= 4'd0;
      r_dcard1     <= 4'd0;
      r_dcard2     <= 4'd0;
      r_dcard3     <= 4'd0;
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_RESULT: begin
          if (start) begin
            r_state      <= S_DEAL_P1;
            r_card_req   <= 1'b1;
            r_pcard1     <= 4'd0;
            r_pcard2     <= 4'd0;
            r_pcard3     <= 4'd0;
            r_dcard1     <= 4'd0;
            r_dcard2     <= 4'd0;
            r_dcard3     <= 4'd0;
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
            r_done       <= 1'b0;
          end
        end
        S_DEAL_P1: begin
          if (w_xfer) begin
            r_pcard1 <= card_in;
            r_state  <= S_DEAL_D1;
          end
        end
        S_DEAL_D1: begin
          if (w_xfer) begin
            r_dcard1 <= card_in;
            r_state  <= S_DEAL_P2;
          end
        end
        S_DEAL_P2: begin
          if (w_xfer) begin
            r_pcard2 <= card_in;
            r_state  <= S_DEAL_D2;
          end
        end
        S_DEAL_D2: begin
          if (w_xfer) begin
            r_dcard2   <= card_in;
            r_state    <= S_DECIDE;
            r_card_req <= 1'b0;
          end
        end
        S_DECIDE: begin
          if (w_natural) begin
            r_state      <= S_RESULT;
            r_done       <= 1'b1;
            r_player_win <= (w_pscore_n >= w_dscore_n);
            r_dealer_win <= (w_dscore_n >= w_pscore_n);
          end else if (w_pscore <= 4'd5) begin
            r_state    <= S_DEAL_P3;
            r_card_req <= 1'b1;
          end else if (w_dscore <= 4'd5) begin
            r_state    <= S_DEAL_D3;
            r_card_req <= 1'b1;
          end else begin
            r_state      <= S_RESULT;
            r_done       <= 1'b1;
            r_player_win <= (w_pscore_n >= w_dscore_n);
            r_dealer_win <= (w_dscore_n >= w_pscore_n);
          end
        end
        S_DEAL_P3: begin
          if (w_xfer) begin
            r_pcard3 <= card_in;
            if (w_bank_draw) begin
              r_state <= S_DEAL_D3;
            end else begin
              r_state      <= S_RESULT;
              r_card_req   <= 1'b0;
              r_done       <= 1'b1;
              r_player_win <= (w_pscore_n >= w_dscore_n);
              r_dealer_win <= (w_dscore_n >= w_pscore_n);
            end
          end
        end
        S_DEAL_D3: begin
          if (w_xfer) begin
            r_dcard3     <= card_in;
            r_state      <= S_RESULT;
            r_card_req   <= 1'b0;
            r_done       <= 1'b1;
            r_player_win <= (w_pscore_n >= w_dscore_n);
            r_dealer_win <= (w_dscore_n >= w_pscore_n);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_card_req <= 1'b0;
        end
      endcase
    end
  end

  assign card_req   = r_card_req;
  assign pcard1     = r_pcard1;
  assign pcard2     = r_pcard2;
  assign pcard3     = r_pcard3;
  assign dcard1     = r_dcard1;
  assign dcard2     = r_dcard2;
  assign dcard3     = r_dcard3;
  assign pscore     = w_pscore;
  assign dscore     = w_dscore;
  assign player_win = r_player_win;
  assign dealer_win = r_dealer_win;
  assign done       = r_done;

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Bench for baccarat_sequencer: directed rounds, stall and reset
// cases, then random decks against a tableau-rule reference model.
module tb_baccarat_sequencer;

  logic       slow_clock;
  logic       resetb;
  logic       start;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_in;
  logic [3:0] pcard1, pcard2, pcard3;
  logic [3:0] dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       player_win, dealer_win, done;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] deck [6];
  logic [3:0] m_p [3];
  logic [3:0] m_d [3];
  int m_ps, m_ds, m_n;

  baccarat_sequencer dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .start      (start),
    .card_req   (card_req),
    .card_valid (card_valid),
    .card_in    (card_in),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .done       (done)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int val(input logic [3:0] c);
    if (c >= 4'd1 && c <= 4'd9)
      return int'(c);
    return 0;
  endfunction

  function automatic bit banker_draws(input int ds, input int v);
    if (ds <= 2) return 1'b1;
    if (ds == 3) return v != 8;
    if (ds == 4) return v inside {[2:7]};
    if (ds == 5) return v inside {[4:7]};
    if (ds == 6) return v inside {[6:7]};
    return 1'b0;
  endfunction

  // Plays the deck by the tableau rules; deck order is P,D,P,D,...
  function automatic void model();
    int v;
    m_p[0] = deck[0]; m_p[1] = deck[2]; m_p[2] = 4'd0;
    m_d[0] = deck[1]; m_d[1] = deck[3]; m_d[2] = 4'd0;
    m_n  = 4;
    m_ps = (val(deck[0]) + val(deck[2])) % 10;
    m_ds = (val(deck[1]) + val(deck[3])) % 10;
    if (m_ps >= 8 || m_ds >= 8) begin
      m_n = 4;
    end else if (m_ps <= 5) begin
      m_p[2] = deck[4];
      m_n  = 5;
      v    = val(deck[4]);
      m_ps = (m_ps + v) % 10;
      if (banker_draws(m_ds, v)) begin
        m_d[2] = deck[5];
        m_n  = 6;
        m_ds = (m_ds + val(deck[5])) % 10;
      end
    end else if (m_ds <= 5) begin
      m_d[2] = deck[4];
      m_n  = 5;
      m_ds = (m_ds + val(deck[4])) % 10;
    end
  endfunction

  task automatic check_result();
    chk("pcard1", pcard1, m_p[0]);
    chk("pcard2", pcard2, m_p[1]);
    chk("pcard3", pcard3, m_p[2]);
    chk("dcard1", dcard1, m_d[0]);
    chk("dcard2", dcard2, m_d[1]);
    chk("dcard3", dcard3, m_d[2]);
    chk("pscore", pscore, m_ps);
    chk("dscore", dscore, m_ds);
    chk("player_win", player_win, m_ps >= m_ds);
    chk("dealer_win", dealer_win, m_ds >= m_ps);
    chk("done", done, 1);
    chk("req_result", card_req, 0);
  endtask

  task automatic play_round(input int stall_pct);
    int idx;
    int cyc;
    bit xfer;
    bit got;
    model();
    idx = 0;
    got = 0;
    @(negedge slow_clock);
    start      = 1'b1;
    card_valid = 1'($urandom_range(0, 1));
    card_in    = 4'($urandom_range(0, 15));
    xfer       = 1'b0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(negedge slow_clock);
      start = 1'b0;
      if (xfer) idx++;
      if (cyc == 1) begin
        chk("clr_pcard1", pcard1, 0);
        chk("clr_done", done, 0);
        chk("req_deal", card_req, 1);
      end
      if (done) begin
        got = 1;
        break;
      end
      if (card_req) begin
        card_valid = ($urandom_range(0, 99) >= stall_pct);
        card_in    = (idx < 6) ? deck[idx] : 4'd0;
      end else begin
        card_valid = 1'($urandom_range(0, 1));
        card_in    = 4'($urandom_range(0, 15));
      end
      xfer = card_req && card_valid;
    end
    chk("round_timeout", got, 1);
    if (stall_pct == 0)
      chk("latency", cyc, m_n + 2);
    chk("ncards", idx, m_n);
    repeat (3) begin
      @(negedge slow_clock);
      card_valid = 1'($urandom_range(0, 1));
      card_in    = 4'($urandom_range(0, 15));
    end
    check_result();
    card_valid = 1'b0;
  endtask

  initial begin
    resetb     = 1'b0;
    start      = 1'b0;
    card_valid = 1'b0;
    card_in    = 4'd0;
    #3;
    chk("rst_req", card_req, 0);
    chk("rst_done", done, 0);
    chk("rst_pcard1", pcard1, 0);
    chk("rst_pwin", player_win, 0);
    repeat (2) @(negedge slow_clock);
    resetb = 1'b1;
    card_valid = 1'b1;
    @(negedge slow_clock);
    chk("idle_req", card_req, 0);
    chk("idle_dcard1", dcard1, 0);
    card_valid = 1'b0;

    deck = '{4'd8, 4'd2, 4'd13, 4'd3, 4'd0, 4'd0};
    play_round(0);
    deck = '{4'd2, 4'd7, 4'd3, 4'd13, 4'd4, 4'd0};
    play_round(0);
    deck = '{4'd1, 4'd1, 4'd4, 4'd2, 4'd8, 4'd5};
    play_round(0);
    deck = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd12, 4'd5};
    play_round(0);
    deck = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd6, 4'd1};
    play_round(0);
    deck = '{4'd9, 4'd9, 4'd6, 4'd6, 4'd5, 4'd5};
    play_round(0);

    // Source stalls in DEAL_D1
    @(negedge slow_clock);
    start = 1'b1;
    card_valid = 1'b0;
    @(negedge slow_clock);
    start = 1'b0;
    card_valid = 1'b1;
    card_in = 4'd8;
    @(negedge slow_clock);
    card_valid = 1'b0;
    card_in = 4'd2;
    repeat (10) begin
      @(negedge slow_clock);
      chk("stall_req", card_req, 1);
      chk("stall_pcard1", pcard1, 8);
      chk("stall_dcard1", dcard1, 0);
    end
    card_valid = 1'b1;
    @(negedge slow_clock);
    chk("stall_accept", dcard1, 2);
    chk("stall_pcard2", pcard2, 0);
    card_in = 4'd13;
    @(negedge slow_clock);
    card_in = 4'd3;
    @(negedge slow_clock);
    card_valid = 1'b0;
    @(negedge slow_clock);
    chk("stall_done", done, 1);
    chk("stall_pwin", player_win, 1);
    chk("stall_dwin", dealer_win, 0);
    chk("stall_pscore", pscore, 8);
    chk("stall_dscore", dscore, 5);

    // Reset pulse between edges in DEAL_P2
    @(negedge slow_clock);
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    card_valid = 1'b1;
    card_in = 4'd9;
    @(negedge slow_clock);
    card_in = 4'd1;
    @(negedge slow_clock);
    card_in = 4'd5;
    #2 resetb = 1'b0;
    #1;
    chk("arst_req", card_req, 0);
    chk("arst_pcard1", pcard1, 0);
    chk("arst_dcard1", dcard1, 0);
    chk("arst_done", done, 0);
    #1 resetb = 1'b1;
    @(negedge slow_clock);
    chk("arst_idle_req", card_req, 0);
    chk("arst_pcard2", pcard2, 0);
    card_valid = 1'b0;
    deck = '{4'd8, 4'd2, 4'd13, 4'd3, 4'd0, 4'd0};
    play_round(0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 6; k++)
        deck[k] = 4'($urandom_range(0, 15));
      play_round((i % 3 == 0) ? 0 : int'($urandom_range(10, 60)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/baccarat_sequencer.md
BACCARAT_SEQUENCER -- requirements
Module: baccarat_sequencer

Interface
REQ-001 SHALL have these ports, clock and reset first: slow_clock  in  1  sole clock, all state changes on its rising edge.
REQ-002 SHALL have: resetb  in  1  asynchronous active-low reset.
REQ-003 SHALL have: start  in  1  level; begins a new round when sampled high in IDLE or RESULT.
REQ-004 SHALL have: card_req  out  1  high while waiting for a card from the card source.
REQ-005 SHALL have: card_valid  in  1  card source presents card_in this cycle.
REQ-006 SHALL have: card_in  in  4  card number, 1=Ace … 13=King.
REQ-007 SHALL have: pcard1, pcard2, pcard3, dcard1, dcard2, dcard3  out  4 each  registered hand cards, 0 = no card.
REQ-008 SHALL have: pscore, dscore  out  4 each  current hand scores.
REQ-009 SHALL have: player_win, dealer_win  out  1 each  result flags, both high = tie.
REQ-010 SHALL have: done  out  1  round complete, result valid.

Function
REQ-011 Card value SHALL be card number for 1-9 and 0 for 0 and 10-15; score SHALL be (sum of three card values) mod 10, computed combinationally from the card registers with a 5-bit intermediate sum.
REQ-012 States SHALL be IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DECIDE, DEAL_P3, DEAL_D3, RESULT.
REQ-013 card_req SHALL be high exactly in the DEAL_* states and low elsewhere.
REQ-014 A card transfer SHALL occur on a rising edge where card_req and card_valid are both high; card_in SHALL be written into the register for the current state on that edge and the FSM SHALL advance on the same edge.
REQ-015 card_valid SHALL be ignored outside DEAL_* states; the source MAY stall indefinitely; there is no timeout.
REQ-016 IDLE or RESULT with start=1 SHALL clear all six card registers, player_win, dealer_win and done, and enter DEAL_P1 on the same edge.
REQ-017 Deal order SHALL be DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> DECIDE.
REQ-018 DECIDE SHALL last one cycle. If pscore or dscore is 8 or 9, go to RESULT. Otherwise, if pscore 0-5, go to DEAL_P3. Otherwise, if dscore 0-5, go to DEAL_D3. Otherwise go to RESULT.
REQ-019 After the DEAL_P3 transfer, the FSM SHALL go to DEAL_D3 or RESULT using dscore and v = value of the pcard3 just written. Draw when dscore is 0-2. Draw when dscore is 3 and v≠8. Draw when dscore is 4 and v in 2-7. Draw when dscore is 5 and v in 4-7. Draw when dscore is 6 and v in 6-7. Stand when dscore is 7.
REQ-020 After the DEAL_D3 transfer, the FSM SHALL go to RESULT.
REQ-021 On the edge entering RESULT, done SHALL be set. player_win SHALL be set if pscore > dscore. dealer_win SHALL be set if dscore > pscore. Both SHALL be set if the scores are equal.
REQ-022 The scores used on the edge entering RESULT SHALL include any card written on that same edge.
REQ-023 RESULT SHALL hold all outputs stable until start=1.
REQ-024 start SHALL be ignored in all states other than IDLE and RESULT.
REQ-025 Minimum round latency, with card_valid held high, SHALL be 6 cycles from leaving IDLE to done=1 for a natural with no third cards.

Reset
REQ-026 resetb low SHALL immediately, without a clock edge, force IDLE and drive all card registers, player_win, dealer_win, done and card_req to 0.
REQ-027 Reset asserted mid-round, including mid-transfer, SHALL abandon the round with no partial card retained.
REQ-028 After resetb deasserts, the FSM SHALL wait in IDLE for start.

Verification
REQ-029 Natural: cards 8,2,K,3 -> pcard1=8, pcard2=K, dcard1=2, dcard2=3, pscore=8, dscore=5; no third card; player_win=1, dealer_win=0, done=1.
REQ-030 Player draws, banker stands: cards 2,7,3,K,4 -> pscore=5 so pcard3=4 (pscore 9); dscore=7 stands; card_req low in RESULT; player_win=1.
REQ-031 Banker rule table, pcard3 value boundaries: dscore 3 with pcard3 8 -> banker stands. dscore 6 with pcard3 Q (value 0) -> banker stands. dscore 6 with pcard3 6 -> DEAL_D3 entered.
REQ-032 Tie and wrap: cards 9,9,6,6,5,5 -> pscore 5, dscore 5; pcard3=5 gives pscore 0; dscore 5 with v=5 draws dcard3=5 giving dscore 0; player_win=1, dealer_win=1.
REQ-033 Stall: card_valid low for 10 cycles in DEAL_D1 -> state and card registers unchanged, card_req held high; the card is accepted on the first cycle card_valid=1.
REQ-034 Async reset pulsed low between clock edges in DEAL_P2 -> outputs 0 immediately; the next start restarts at DEAL_P1 with pcard1 cleared.
